dmem_port_arbiter: RTL and testbench

//  Shares the single-port data memory between two requesters.
//  - Port 0 is the core load/store path.
//  - Port 1 is a DMA/debug loader that preloads or inspects memory.

---
 rtl/dmem_arb_pkg.sv | 10 +
 rtl/dmem_arb_rr.sv | 23 ++
 rtl/dmem_port_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory port arbiter: port indices and FSM state encoding.
package dmem_arb_pkg;

    localparam logic P_CORE = 1'b0;
    localparam logic P_DMA  = 1'b1;

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;

endpackage

// File: rtl/dmem_arb_rr.sv
// Two-way round-robin grant: a lone requester wins, a tie goes to the port that did not own last.
module dmem_arb_rr
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] gnt
);

    always_comb begin
        // NOTE: default assignment first so every path drives gnt and no latch is inferred.
        gnt = req;
        if (req == 2'b11) begin
            gnt = 2'b00;
            if (last_owner == P_DMA) begin
                gnt[P_CORE] = 1'b1;
            end else begin
                gnt[P_DMA] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core (port 0) and a DMA/debug loader (port 1).
// Optional port-1 burst lock is built only when DMEM_ARB_LOCK_EN is defined.
module dmem_port_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          c_req,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr,
    input  logic [DW-1:0] c_wdata,
    output logic          c_gnt,
    output logic          c_rvalid,
    output logic [DW-1:0] c_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    input  logic          d_lock,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    logic [1:0]    rr_gnt;
    logic [1:0]    gnt;
    logic          last_owner_q, last_owner_d;
    logic          pend_rd_q, pend_rd_d;
    logic          pend_owner_q, pend_owner_d;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wd_q;

    dmem_arb_rr u_rr (
        .req        ({d_req, c_req}),
        .last_owner (last_owner_q),
        .gnt        (rr_gnt)
    );

`ifdef DMEM_ARB_LOCK_EN
    localparam int CW = ($clog2(MAX_BURST) > 0) ? $clog2(MAX_BURST) : 1;

    logic [0:0]    state_q, state_d;
    logic [CW-1:0] burst_cnt_q, burst_cnt_d;

    // The granting cycle that enters LOCK is the burst's first grant, so port 0
    // waits at most MAX_BURST cycles; MAX_BURST == 1 therefore never locks.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        if (state_q == ST_LOCK) begin
            if (!d_lock || !d_req || (burst_cnt_q == CW'(MAX_BURST - 1))) begin
                state_d     = ST_ARB;
                burst_cnt_d = '0;
            end else begin
                burst_cnt_d = burst_cnt_q + CW'(1);
            end
        end else if (rr_gnt[P_DMA] && d_lock && (MAX_BURST > 1)) begin
            state_d     = ST_LOCK;
            burst_cnt_d = CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_ARB;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign gnt = (state_q == ST_LOCK) ? {d_req, 1'b0} : rr_gnt;
`else
    logic unused_lock;

    assign unused_lock = d_lock & (MAX_BURST >= 1) & (ST_LOCK != ST_ARB);
    assign gnt         = rr_gnt;
`endif

    assign c_gnt = gnt[P_CORE];
    assign d_gnt = gnt[P_DMA];

    // Only port 1 is granted inside a burst, so last_owner is already P_DMA whenever LOCK exits.
    always_comb begin
        last_owner_d = last_owner_q;
        if (gnt[P_CORE]) begin
            last_owner_d = P_CORE;
        end else if (gnt[P_DMA]) begin
            last_owner_d = P_DMA;
        end
    end

    // With no grant the address/data buses replay the last driven value from flops.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = addr_q;
        mem_wd   = wd_q;
        if (gnt[P_CORE]) begin
            mem_we   = c_we;
            mem_addr = c_addr;
            mem_wd   = c_wdata;
        end else if (gnt[P_DMA]) begin
            mem_we   = d_we;
            mem_addr = d_addr;
            mem_wd   = d_wdata;
        end
    end

    assign pend_rd_d    = (|gnt) && !mem_we;
    assign pend_owner_d = gnt[P_DMA] ? P_DMA : P_CORE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_owner_q <= P_DMA;
            pend_rd_q    <= 1'b0;
            pend_owner_q <= P_CORE;
            addr_q       <= '0;
            wd_q         <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            pend_rd_q    <= pend_rd_d;
            pend_owner_q <= pend_owner_d;
            addr_q       <= mem_addr;
            wd_q         <= mem_wd;
        end
    end

    assign c_rvalid = pend_rd_q && (pend_owner_q == P_CORE);
    assign d_rvalid = pend_rd_q && (pend_owner_q == P_DMA);
    assign c_rdata  = c_rvalid ? mem_rd : '0;
    assign d_rdata  = d_rvalid ? mem_rd : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus a random phase against a
// behavioural model; honours DMEM_ARB_LOCK_EN when the RTL is built with it.
module tb_dmem_port_arbiter;

    localparam int AW        = 32;
    localparam int DW        = 32;
    localparam int MAX_BURST = 4;
`ifdef DMEM_ARB_LOCK_EN
    localparam bit LOCK_ON = 1'b1;
`else
    localparam bit LOCK_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          c_req, c_we, d_req, d_we, d_lock;
    logic [AW-1:0] c_addr, d_addr;
    logic [DW-1:0] c_wdata, d_wdata;
    logic          c_gnt, c_rvalid, d_gnt, d_rvalid, mem_we;
    logic [DW-1:0] c_rdata, d_rdata, mem_wd;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rd;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)) u_dut (
        .clk(clk), .rst(rst),
        .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
        .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_lock(d_lock),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // Data_Memory stand-in: synchronous write, registered read.
    logic [DW-1:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[11:2]] <= mem_wd;
        mem_rd <= mem[mem_addr[11:2]];
    end

    int total = 0;
    int bad   = 0;

    // Behavioural reference: who owned memory last, how long the current locked burst is,
    // what the next cycle's read return should carry, and the expected memory contents.
    logic [DW-1:0] exp_mem [0:1023];
    int            ref_last;
    int            lock_run;
    bit            exp_pend;
    int            exp_pend_port;
    logic [DW-1:0] exp_pend_data;
    logic [AW-1:0] exp_addr_hold;
    logic [DW-1:0] exp_wd_hold;
    logic          obs_c, obs_d, obs_we;
    int            seq [0:9];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        ref_last      = 1;
        lock_run      = 0;
        exp_pend      = 1'b0;
        exp_pend_port = 0;
        exp_pend_data = '0;
        exp_addr_hold = '0;
        exp_wd_hold   = '0;
    endtask

    // One clock cycle with the inputs already driven: check at negedge, advance the model,
    // return just after the next posedge.
    task automatic cycle();
        bit            ec, ed, ewe;
        int            win;
        logic [AW-1:0] ea;
        logic [DW-1:0] ewd;
        @(negedge clk);
        ec = 1'b0;
        ed = 1'b0;
        if (LOCK_ON && lock_run > 0) ed = d_req;
        else if (c_req && d_req) begin
            if (ref_last == 1) ec = 1'b1; else ed = 1'b1;
        end else begin
            ec = c_req;
            ed = d_req;
        end
        win = ec ? 0 : (ed ? 1 : -1);
        ewe = (win == 0) ? c_we    : (win == 1) ? d_we    : 1'b0;
        ea  = (win == 0) ? c_addr  : (win == 1) ? d_addr  : exp_addr_hold;
        ewd = (win == 0) ? c_wdata : (win == 1) ? d_wdata : exp_wd_hold;
        obs_c  = c_gnt;
        obs_d  = d_gnt;
        obs_we = mem_we;
        check("c_gnt", 32'(c_gnt), 32'(ec));
        check("d_gnt", 32'(d_gnt), 32'(ed));
        check("mem_we", 32'(mem_we), 32'(ewe));
        check("mem_addr", mem_addr, ea);
        check("mem_wd", mem_wd, ewd);
        check("c_rvalid", 32'(c_rvalid), 32'(exp_pend && exp_pend_port == 0));
        check("d_rvalid", 32'(d_rvalid), 32'(exp_pend && exp_pend_port == 1));
        check("c_rdata", c_rdata, (exp_pend && exp_pend_port == 0) ? exp_pend_data : '0);
        check("d_rdata", d_rdata, (exp_pend && exp_pend_port == 1) ? exp_pend_data : '0);
        exp_pend      = (win >= 0) && !ewe;
        exp_pend_port = win;
        exp_pend_data = exp_mem[ea[11:2]];
        if (win >= 0) begin
            if (ewe) exp_mem[ea[11:2]] = ewd;
            exp_addr_hold = ea;
            exp_wd_hold   = ewd;
            ref_last      = win;
        end
        if (LOCK_ON) begin
            if (lock_run > 0) begin
                if (ed && d_lock && lock_run + 1 < MAX_BURST) lock_run++;
                else lock_run = 0;
            end else if (ed && d_lock && MAX_BURST > 1) begin
                lock_run = 1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        c_req = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_lock = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        drive_idle();
        model_reset();

        // Reset state
        @(negedge clk);
        check("rst_c_gnt", 32'(c_gnt), 0);
        check("rst_d_gnt", 32'(d_gnt), 0);
        check("rst_mem_we", 32'(mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wd", mem_wd, 0);
        check("rst_c_rvalid", 32'(c_rvalid), 0);
        check("rst_d_rvalid", 32'(d_rvalid), 0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Preload words 16..31 through the DMA port; word 28 (byte 0x70) holds 0x20
        for (int i = 0; i < 16; i++) begin
            d_req = 1'b1; d_we = 1'b1;
            d_addr  = 32'h40 + 32'(i * 4);
            d_wdata = (i == 12) ? 32'h20 : $urandom;
            cycle();
        end
        drive_idle();

        // Single core read of 0x70
        c_req = 1'b1; c_we = 1'b0; c_addr = 32'h70;
        cycle();
        check("single_c_gnt", 32'(obs_c), 1);
        drive_idle();
        check("single_c_rvalid", 32'(c_rvalid), 1);
        check("single_c_rdata", c_rdata, 32'h20);
        check("single_d_rvalid", 32'(d_rvalid), 0);

        // DMA read so port 1 owns last, then four contended reads: C,D,C,D
        d_req = 1'b1; d_addr = 32'h4C;
        cycle();
        c_req = 1'b1; c_addr = 32'h44;
        d_req = 1'b1; d_addr = 32'h48;
        for (int i = 0; i < 4; i++) begin
            cycle();
            seq[i] = obs_d ? 1 : (obs_c ? 0 : 2);
            check("contend_owner", 32'(seq[i]), 32'(i % 2));
            check("contend_c_rvalid", 32'(c_rvalid), 32'(i % 2 == 0));
            check("contend_d_rvalid", 32'(d_rvalid), 32'(i % 2 == 1));
        end
        drive_idle();

        // DMA writes 0x40 in N, core reads 0x40 in N+1, data returns in N+2
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        cycle();
        drive_idle();
        c_req = 1'b1; c_addr = 32'h40;
        cycle();
        check("wr_rd_mem_we_n1", 32'(obs_we), 0);
        drive_idle();
        check("wr_rd_c_rvalid", 32'(c_rvalid), 1);
        check("wr_rd_c_rdata", c_rdata, 32'hDEAD_BEEF);

        // Idle cycle
        cycle();
        check("idle_gnt", {30'd0, obs_d, obs_c}, 0);
        check("idle_mem_we", 32'(obs_we), 0);
        check("idle_rvalid", {30'd0, d_rvalid, c_rvalid}, 0);

        // Core loses a tie and drops its request; the next tie still goes to the core
        c_req = 1'b1; c_addr = 32'h50; d_req = 1'b1; d_addr = 32'h54;
        cycle();
        check("drop_d_wins", 32'(obs_d), 1);
        drive_idle();
        cycle();
        c_req = 1'b1; c_addr = 32'h50; d_req = 1'b1; d_addr = 32'h54;
        cycle();
        check("drop_c_wins", 32'(obs_c), 1);

        // Lock request held with both ports requesting
        d_lock = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            seq[i] = obs_d ? 1 : (obs_c ? 0 : 2);
            check("lock_owner", 32'(seq[i]), LOCK_ON ? 32'(i % 5 != 4) : 32'(i % 2 == 0));
        end
        drive_idle();
        cycle();

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            c_req   = $urandom_range(0, 1) == 1;
            c_we    = $urandom_range(0, 2) == 0;
            c_addr  = 32'h40 + 32'($urandom_range(0, 15) * 4);
            c_wdata = $urandom;
            d_req   = $urandom_range(0, 2) != 0;
            d_we    = $urandom_range(0, 2) == 0;
            d_addr  = 32'h40 + 32'($urandom_range(0, 15) * 4);
            d_wdata = $urandom;
            d_lock  = $urandom_range(0, 3) != 0;
            cycle();
        end
        drive_idle();
        cycle();
        cycle();

        // Reset asserted the cycle after a core read grant discards the return
        c_req = 1'b1; c_addr = 32'h70;
        cycle();
        drive_idle();
        rst = 1'b0;
        #1;
        check("midrst_c_rvalid", 32'(c_rvalid), 0);
        check("midrst_c_rdata", c_rdata, 0);
        check("midrst_d_rvalid", 32'(d_rvalid), 0);
        check("midrst_mem_addr", mem_addr, 0);
        check("midrst_mem_wd", mem_wd, 0);
        check("midrst_gnt", {29'd0, mem_we, d_gnt, c_gnt}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rvalid", {30'd0, d_rvalid, c_rvalid}, 0);
        c_req = 1'b1; c_addr = 32'h44; d_req = 1'b1; d_addr = 32'h48;
        cycle();
        check("post_rst_tie_c", 32'(obs_c), 1);
        drive_idle();
        cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
